fifo_uart_rx: RTL and testbench
===============================

// Module: fifo_uart_rx
// PURPOSE
//  Upstream feeder for the 16x8 byte FIFO: receives asynchronous UART frames on rxd,
//  deserialises them to bytes and pushes each good byte into the FIFO write port.
//  Frame format: 8N1, LSB first. Bytes that arrive while the FIFO is full are dropped
//  and flagged. Framing errors are also dropped and flagged.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per UART bit; legal range >= 4, even values only.
//  DATA_W         8  byte width; must match the FIFO din width.
// PORTS
//  clk        in   1       system clock; all state updates on posedge.
//  rst        in   1       asynchronous, active-high reset.
//  rxd        in   1       serial line, asynchronous to clk, idle high.
//  full       in   1       FIFO full flag.
//  err_clr    in   1       one-cycle pulse; clears frame_err and overflow.
//  wr         out  1       FIFO write strobe; one-cycle pulse per accepted byte.
//  din        out  DATA_W  byte to the FIFO; registered, valid while wr=1, held until next wr.
//  busy       out  1       high from start-edge detection until return to IDLE.
//  frame_err  out  1       sticky flag: stop bit sampled low.
//  overflow   out  1       sticky flag: good byte dropped because full=1.
// BEHAVIOUR
//  Reset values: wr=0, din=0, busy=0, frame_err=0, overflow=0. Both sync flops reset to 1.
//  rxd passes through a 2-flop synchroniser; rxd_s below is the synchronised value.
//  Baud counter width is $clog2(CLKS_PER_BIT). It clears on every state change.
//  FSM states and transitions:
//   IDLE      : rxd_s==0 -> START, cnt=0.
//   START     : at cnt==CLKS_PER_BIT/2-1, sample rxd_s.
//               1 -> IDLE (glitch; no flag). 0 -> DATA, bit index=0.
//   DATA      : at cnt==CLKS_PER_BIT-1, shift rxd_s into shreg[idx].
//               After idx==DATA_W-1 -> STOP.
//   STOP      : at cnt==CLKS_PER_BIT-1, sample rxd_s and full together.
//               rxd_s=1, full=0 -> wr=1 and din=shreg on the next cycle; -> IDLE.
//               rxd_s=1, full=1 -> overflow<=1, no wr; -> IDLE.
//               rxd_s=0         -> frame_err<=1, no wr; -> WAIT_HIGH.
//   WAIT_HIGH : stay until rxd_s==1 -> IDLE. A low line is never taken as a new start.
//  Sampling and latency:
//   All samples fall at bit centres (start sample + n*CLKS_PER_BIT).
//   wr rises exactly 1 cycle after the stop-bit sample and lasts exactly 1 cycle.
//  Back-to-back frames: a start edge seen on the first IDLE cycle after STOP is accepted.
//   No idle gap is required.
//  full is sampled only at the stop-bit sample; its value at other times is ignored.
//  The FIFO gives wr priority over rd, so wr is never suppressed by FIFO read activity.
//  Sticky flags: err_clr clears both. If a set and err_clr occur in the same cycle,
//   the set wins and the flag stays 1.
//  busy=1 in START, DATA, STOP and WAIT_HIGH; 0 in IDLE.
//  Reset mid-frame: immediate return to IDLE. The partial byte is discarded; no wr.
// STRUCTURE
//  fifo_uart_pkg:
//   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
//   localparam DATA_W_DEF=8.
//   localparam CLKS_PER_BIT_DEF=16.
//  Sub-module uart_rx_sync: 2-flop synchroniser.
//   Ports: clk, rst, d, q. Reset value 1.
//  FSM, baud counter, shift register and flags live in fifo_uart_rx.
// TESTING (CLKS_PER_BIT=16; bench connects wr/din/full to the 16-deep FIFO)
//  1. Send frame 0xA5 -> single 1-cycle wr with din=0xA5, 1 cycle after stop sample;
//     FIFO read then returns 0xA5.
//  2. Send 0x00..0x0F, then 0xFF -> 16 wr pulses, full=1, no wr for 0xFF, overflow=1;
//     16 reads return 0x00..0x0F in order.
//  3. Send 0x55 with stop bit low, hold rxd low 40 cycles, then send 0x3C
//     -> frame_err=1, no wr for 0x55; one wr with din=0x3C.
//  4. Drive rxd low for 4 cycles, then high -> busy pulses, returns to IDLE;
//     no wr, no flags set.
//  5. Assert rst during data bit 3 of a frame -> busy=0, wr=0, din=0 immediately;
//     a following 0x81 is received correctly.
//  6. With FIFO full, pulse err_clr in the same cycle overflow is set
//     -> overflow reads 1. A later lone err_clr -> overflow=0.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared types and default parameters for the UART receiver feeding the 16x8 byte FIFO.
package fifo_uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;

    localparam int DATA_W_DEF       = 8;
    localparam int CLKS_PER_BIT_DEF = 16;

endpackage

// File: rtl/fifo_uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_p0 <= 1'b1;
            q       <= 1'b1;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/fifo_uart_rx.sv
// 8N1 UART receiver: deserialises frames on rxd and pushes good bytes into the FIFO write port,
// flagging framing errors and bytes dropped on a full FIFO.
module fifo_uart_rx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_W       = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    input  logic              full,
    input  logic              err_clr,
    output logic              wr,
    output logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              frame_err,
    output logic              overflow
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    rx_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shreg;
    logic              rxd_s;

    logic half_end;
    logic bit_end;
    logic stop_smp;
    logic accept;
    logic ovf_set;
    logic fe_set;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    assign half_end = (cnt == HALF_LAST);
    assign bit_end  = (cnt == BIT_LAST);
    assign stop_smp = (state == STOP) && bit_end;
    assign accept   = stop_smp &&  rxd_s && !full;
    assign ovf_set  = stop_smp &&  rxd_s &&  full;
    assign fe_set   = stop_smp && !rxd_s;
    assign busy     = (state != IDLE);

    // Control path: FSM, baud counter, bit index, write strobe and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            wr        <= 1'b0;
            din       <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            wr <= accept;
            if (accept) begin
                din <= shreg;
            end

            // A set in the same cycle as err_clr takes precedence.
            if (fe_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxd_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (half_end) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rxd_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= rxd_s ? IDLE : WAIT_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // A line stuck low after a bad stop bit must not look like a new start.
                    cnt <= '0;
                    if (rxd_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Data path: shift register needs no reset, every bit is rewritten before use.
    always_ff @(posedge clk) begin
        if ((state == DATA) && bit_end) begin
            shreg[idx] <= rxd_s;
        end
    end

endmodule

// File: tb/tb_fifo_uart_rx.sv
// Randomised bench for fifo_uart_rx against a frame-level model and a behavioural 16-deep FIFO.
module tb_fifo_uart_rx;

    localparam int C     = 16;
    localparam int H     = C / 2;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int LAT   = 3 + H + 9 * C;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rxd = 1'b1;
    logic          full;
    logic          err_clr = 1'b0;
    logic          wr;
    logic [DW-1:0] din;
    logic          busy;
    logic          frame_err;
    logic          overflow;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int wr_count = 0;
    int busy_cnt = 0;
    int last_wr_cyc = 0;
    int last_t0 = 0;
    bit wr_prev = 1'b0;
    bit abort = 1'b0;
    bit m_fe = 1'b0;
    bit m_ovf = 1'b0;

    logic [7:0] fifo_q[$];
    logic [7:0] model_fifo[$];
    logic [7:0] exp_q[$];

    fifo_uart_rx #(.CLKS_PER_BIT(C), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .full      (full),
        .err_clr   (err_clr),
        .wr        (wr),
        .din       (din),
        .busy      (busy),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural FIFO on the write port.
    always @(posedge clk) begin
        if (wr && fifo_q.size() < DEPTH) fifo_q.push_back(din);
    end
    always @(negedge clk) full = (fifo_q.size() >= DEPTH);

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (wr) begin
            wr_count++;
            last_wr_cyc = cyc;
            chk("wr_width", wr_prev, 0);
            chk("wr_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("din", din, exp_q.pop_front());
        end
        wr_prev = wr;
    end

    // Drives one 8N1 frame; the model decides the outcome when the stop bit begins.
    task automatic send_frame(input logic [7:0] b, input bit stop);
        @(posedge clk);
        #1;
        last_t0 = cyc;
        rxd = 1'b0;
        repeat (C) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            if (abort) begin
                #1 rxd = 1'b1;
                return;
            end
            #1 rxd = b[i];
            repeat (C) @(posedge clk);
        end
        if (abort) begin
            #1 rxd = 1'b1;
            return;
        end
        if (!stop) begin
            m_fe = 1'b1;
        end else if (model_fifo.size() < DEPTH) begin
            model_fifo.push_back(b);
            exp_q.push_back(b);
        end else begin
            m_ovf = 1'b1;
        end
        #1 rxd = stop;
        repeat (C - 1) @(posedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 4000) begin
            @(posedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
        repeat (4) @(posedge clk);
    endtask

    task automatic read_all(input string tag);
        int n;
        logic [7:0] got;
        logic [7:0] exp;
        chk({tag, "_level"}, fifo_q.size(), model_fifo.size());
        n = model_fifo.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            exp = model_fifo.pop_front();
            got = (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'hxx;
            chk({tag, "_rd"}, got, exp);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic clear_err();
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        m_fe  = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_frame_err"}, frame_err, m_fe);
        chk({tag, "_overflow"}, overflow, m_ovf);
    endtask

    initial begin
        int base;
        int bbase;
        #1;
        chk("rst_wr", wr, 0);
        chk("rst_din", din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overflow", overflow, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        // Single frame, exact latency
        base = wr_count;
        send_frame(8'hA5, 1'b1);
        wait_idle();
        chk("t1_wrcnt", wr_count - base, 1);
        chk("t1_latency", last_wr_cyc - last_t0, LAT);
        check_flags("t1");
        read_all("t1");

        // Random back-to-back bytes
        base = wr_count;
        for (int i = 0; i < 6; i++) send_frame(8'($urandom), 1'b1);
        wait_idle();
        chk("rnd_wrcnt", wr_count - base, 6);
        check_flags("rnd");
        read_all("rnd");

        // Fill the FIFO, then one more byte overflows
        base = wr_count;
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_idle();
        chk("t2_wrcnt", wr_count - base, 16);
        chk("t2_full", full, 1);
        check_flags("t2");

        // err_clr in the same cycle as an overflow set
        clear_err();
        check_flags("t6_clr");
        fork
            send_frame(8'($urandom), 1'b1);
            begin
                @(posedge clk);
                repeat (LAT - 1) @(posedge clk);
                #1 err_clr = 1'b1;
                @(posedge clk);
                #1 err_clr = 1'b0;
            end
        join
        wait_idle();
        chk("t6_overflow_kept", overflow, 1);
        check_flags("t6_set");
        clear_err();
        chk("t6_overflow_cleared", overflow, 0);
        read_all("t2");

        // Framing error, line held low, then a good frame
        base = wr_count;
        send_frame(8'h55, 1'b0);
        repeat (40) @(posedge clk);
        chk("t3_busy_low", busy, 1);
        #1 rxd = 1'b1;
        repeat (C) @(posedge clk);
        send_frame(8'h3C, 1'b1);
        wait_idle();
        chk("t3_wrcnt", wr_count - base, 1);
        check_flags("t3");
        read_all("t3");

        // Short glitch on the line
        clear_err();
        base  = wr_count;
        bbase = busy_cnt;
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (30) @(posedge clk);
        chk("t4_busy_seen", busy_cnt > bbase, 1);
        chk("t4_busy_end", busy, 0);
        chk("t4_wrcnt", wr_count - base, 0);
        check_flags("t4");

        // Reset in the middle of data bit 3, then a clean frame
        base = wr_count;
        fork
            send_frame(8'hC3, 1'b1);
            begin
                @(posedge clk);
                repeat (4 * C + H) @(posedge clk);
                #1 rst = 1'b1;
                abort = 1'b1;
                #1;
                chk("t5_busy", busy, 0);
                chk("t5_wr", wr, 0);
                chk("t5_din", din, 0);
                m_fe  = 1'b0;
                m_ovf = 1'b0;
            end
        join
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        abort = 1'b0;
        repeat (4) @(posedge clk);
        send_frame(8'h81, 1'b1);
        wait_idle();
        chk("t5_wrcnt", wr_count - base, 1);
        check_flags("t5");
        read_all("t5");

        // Random mix of good and bad stop bits
        for (int i = 0; i < 6; i++) begin
            base = wr_count;
            send_frame(8'($urandom), 1'($urandom_range(0, 3) != 0));
            #1 rxd = 1'b1;
            repeat (C) @(posedge clk);
            wait_idle();
            check_flags("mix");
            read_all("mix");
            clear_err();
        end
        chk("exp_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
